// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: pulses the PLL reset, waits for lock, qualifies lock
// stability, then releases the system reset. Recovers from lock timeout and
// lock loss, and reports state / retry count / sticky fail for debug.
module pll_reset_seq #(
  parameter int unsigned RST_CYCLES    = 27,
  parameter int unsigned LOCK_TIMEOUT  = 27000,
  parameter int unsigned STABLE_CYCLES = 2700,
  parameter int unsigned MAX_RETRIES   = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pll_lock,
  input  logic       soft_rst_req,
  output logic       pll_rst,
  output logic       sys_resetn,
  output logic [1:0] state,
  output logic [7:0] retry_cnt,
  output logic       fail
);

  localparam int unsigned MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_P   = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_P) + 1;
  localparam int unsigned RETRY_W = 8;

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic                 fail_q, fail_d;
  logic                 pll_rst_q, pll_rst_d;
  logic                 sys_resetn_q, sys_resetn_d;
  logic                 lock_meta_q, lock_s_q;

  // Two-flop synchronizer for the asynchronous PLL lock
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock;
      lock_s_q    <= lock_meta_q;
    end
  end

  // Next-state, counter, retry and output-flop inputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;

    case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        // lock wins over a coincident timeout
        if (lock_s_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = ST_PLL_RST;
          cnt_d   = '0;
          if (retry_q != {RETRY_W{1'b1}}) begin
            retry_d = retry_q + RETRY_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STABLE: begin
        if (!lock_s_q) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (!lock_s_q) begin
          state_d = ST_WAIT_LOCK;
        end
      end
      default: begin
        state_d = ST_PLL_RST;
        cnt_d   = '0;
      end
    endcase

    // soft reset request overrides every lock/timeout transition
    if (soft_rst_req) begin
      state_d = ST_PLL_RST;
      cnt_d   = '0;
      retry_d = retry_q;
    end

    fail_d       = fail_q | (retry_d >= RETRY_MAX);
    pll_rst_d    = (state_d == ST_PLL_RST);
    sys_resetn_d = (state_d == ST_RUN);
  end

  // State, counter, status and dedicated output flops
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_PLL_RST;
      cnt_q        <= '0;
      retry_q      <= '0;
      fail_q       <= 1'b0;
      pll_rst_q    <= 1'b1;
      sys_resetn_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      fail_q       <= fail_d;
      pll_rst_q    <= pll_rst_d;
      sys_resetn_q <= sys_resetn_d;
    end
  end

  assign pll_rst    = pll_rst_q;
  assign sys_resetn = sys_resetn_q;
  assign state      = state_q;
  assign retry_cnt  = retry_q;
  assign fail       = fail_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq with small timing parameters.
module tb_pll_reset_seq;

  logic       clk;
  logic       resetn;
  logic       pll_lock;
  logic       soft_rst_req;
  logic       pll_rst;
  logic       sys_resetn;
  logic [1:0] state;
  logic [7:0] retry_cnt;
  logic       fail;

  int total;
  int bad;

  pll_reset_seq #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (16),
    .STABLE_CYCLES(8),
    .MAX_RETRIES  (2)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .pll_lock    (pll_lock),
    .soft_rst_req(soft_rst_req),
    .pll_rst     (pll_rst),
    .sys_resetn  (sys_resetn),
    .state       (state),
    .retry_cnt   (retry_cnt),
    .fail        (fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance n rising edges, leaving time 1 unit past the last one
  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input logic prst,
                           input logic sysn, input logic [7:0] rc, input logic f);
    check({tag, ".state"},      8'(state),      8'(st));
    check({tag, ".pll_rst"},    8'(pll_rst),    8'(prst));
    check({tag, ".sys_resetn"}, 8'(sys_resetn), 8'(sysn));
    check({tag, ".retry_cnt"},  retry_cnt,      rc);
    check({tag, ".fail"},       8'(fail),       8'(f));
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    resetn       = 1'b1;
    pll_lock     = 1'b0;
    soft_rst_req = 1'b0;
    #2 resetn = 1'b0;
    #1 check_all("reset", 2'd0, 1'b1, 1'b0, 8'd0, 1'b0);
    ticks(2);
    check_all("reset_clk", 2'd0, 1'b1, 1'b0, 8'd0, 1'b0);

    // 1: normal bring-up
    resetn = 1'b1;
    ticks(3);
    check_all("t1_rst3", 2'd0, 1'b1, 1'b0, 8'd0, 1'b0);
    ticks(1);
    check_all("t1_rst_fall", 2'd1, 1'b0, 1'b0, 8'd0, 1'b0);
    ticks(2);
    pll_lock = 1'b1;
    ticks(2);
    check("t1_sync2", 8'(state), 8'd1);
    ticks(1);
    check("t1_stable", 8'(state), 8'd2);
    ticks(7);
    check_all("t1_edge10", 2'd2, 1'b0, 1'b0, 8'd0, 1'b0);
    ticks(1);
    check_all("t1_run", 2'd3, 1'b0, 1'b1, 8'd0, 1'b0);

    // 4: lock loss in RUN, then timeout
    pll_lock = 1'b0;
    ticks(2);
    check_all("t4_run2", 2'd3, 1'b0, 1'b1, 8'd0, 1'b0);
    ticks(1);
    check_all("t4_wait", 2'd1, 1'b0, 1'b0, 8'd0, 1'b0);
    ticks(15);
    check("t4_wait15", 8'(state), 8'd1);
    ticks(1);
    check_all("t4_timeout", 2'd0, 1'b1, 1'b0, 8'd1, 1'b0);

    // 2: repeated timeouts, fail at retry 2
    ticks(4);
    check_all("t2_wait", 2'd1, 1'b0, 1'b0, 8'd1, 1'b0);
    ticks(16);
    check_all("t2_fail", 2'd0, 1'b1, 1'b0, 8'd2, 1'b1);
    ticks(20);
    check_all("t2_retry3", 2'd0, 1'b1, 1'b0, 8'd3, 1'b1);
    ticks(4);
    pll_lock = 1'b1;
    ticks(3);
    check("t2_stable", 8'(state), 8'd2);
    ticks(8);
    check_all("t2_run", 2'd3, 1'b0, 1'b1, 8'd3, 1'b1);

    // 3: lock glitch in STABLE
    pll_lock = 1'b0;
    ticks(3);
    check("t3_wait", 8'(state), 8'd1);
    pll_lock = 1'b1;
    ticks(3);
    check("t3_stable", 8'(state), 8'd2);
    ticks(5);
    pll_lock = 1'b0;
    ticks(1);
    pll_lock = 1'b1;
    ticks(1);
    check("t3_still_stable", 8'(state), 8'd2);
    ticks(1);
    check_all("t3_back_wait", 2'd1, 1'b0, 1'b0, 8'd3, 1'b1);
    ticks(1);
    check("t3_restable", 8'(state), 8'd2);
    ticks(7);
    check_all("t3_not_yet", 2'd2, 1'b0, 1'b0, 8'd3, 1'b1);
    ticks(1);
    check_all("t3_run", 2'd3, 1'b0, 1'b1, 8'd3, 1'b1);

    // 5a: soft reset pulse in RUN
    soft_rst_req = 1'b1;
    ticks(1);
    soft_rst_req = 1'b0;
    check_all("t5_soft_run", 2'd0, 1'b1, 1'b0, 8'd3, 1'b1);
    pll_lock = 1'b0;
    ticks(4);
    check("t5_wait", 8'(state), 8'd1);
    // 5b: soft reset coincident with timeout
    ticks(15);
    soft_rst_req = 1'b1;
    ticks(1);
    check_all("t5_soft_timeout", 2'd0, 1'b1, 1'b0, 8'd3, 1'b1);
    ticks(2);
    soft_rst_req = 1'b0;
    ticks(3);
    check("t5_held_cnt", 8'(state), 8'd0);
    ticks(1);
    check("t5_release", 8'(state), 8'd1);

    // lock arriving on the timeout cycle wins
    ticks(13);
    pll_lock = 1'b1;
    ticks(2);
    check("tie_wait", 8'(state), 8'd1);
    ticks(1);
    check_all("tie_lock_wins", 2'd2, 1'b0, 1'b0, 8'd3, 1'b1);

    // 6: async reset mid-STABLE
    ticks(3);
    #2 resetn = 1'b0;
    #1 check_all("t6_async", 2'd0, 1'b1, 1'b0, 8'd0, 1'b0);
    @(posedge clk);
    #1 resetn = 1'b1;
    ticks(3);
    check("t6_rst3", 8'(state), 8'd0);
    ticks(1);
    check_all("t6_wait", 2'd1, 1'b0, 1'b0, 8'd0, 1'b0);
    ticks(1);
    check("t6_stable", 8'(state), 8'd2);
    ticks(7);
    check("t6_not_yet", 8'(sys_resetn), 8'd0);
    ticks(1);
    check_all("t6_run", 2'd3, 1'b0, 1'b1, 8'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
